// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-beat memory port between the instruction-fetch side (i_*)
// and the load/store side (d_*). Ties are broken round-robin. The winning
// request is latched, so the memory side only ever sees registered values. The
// arbiter then waits for m_ack, with an optional timeout, and returns a
// one-cycle ready pulse to the owner.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_req/i_addr          : fetch request (level, held until i_ready)
//   i_ready/i_rdata/i_err : fetch completion pulse, word, timeout flag
//   d_req/d_we/d_addr/d_wdata/d_width : load/store request
//   d_ready/d_rdata/d_err : load/store completion pulse, word, timeout flag
//   m_req/m_we/m_addr/m_wdata/m_width : memory request (held while waiting)
//   m_ack/m_rdata         : memory completion strobe and read data
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_width,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [1:0]        m_width,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // The counter only has to reach TIMEOUT-1.
    localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int              LAST_I  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LAST_I);
    localparam logic            TO_EN   = (TIMEOUT != 0);

    logic [1:0]        state;
    logic              owner;
    logic              last_grant;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [1:0]        lat_width;

    logic grant_d;
    logic timeout_hit;

    // D wins when it is the only requester, or when both request and I had the
    // previous grant. The reset value of last_grant is I, so D takes the first tie.
    assign grant_d     = d_req && (!i_req || (last_grant == OWN_I));
    assign timeout_hit = TO_EN && (cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_I;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_width  <= 2'b00;
            i_rdata    <= '0;
            i_err      <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        owner      <= grant_d;
                        last_grant <= grant_d;
                        cnt        <= '0;
                        state      <= S_ISSUE;
                        if (grant_d) begin
                            lat_we    <= d_we;
                            lat_addr  <= d_addr;
                            lat_wdata <= d_wdata;
                            lat_width <= d_width;
                        end else begin
                            // Fetches are always full-word reads.
                            lat_we    <= 1'b0;
                            lat_addr  <= i_addr;
                            lat_wdata <= '0;
                            lat_width <= 2'b10;
                        end
                    end
                end
                S_ISSUE: begin
                    // An ack in the expiry cycle takes priority: the data is real.
                    if (m_ack) begin
                        if (owner == OWN_D) begin
                            d_rdata <= m_rdata;
                            d_err   <= 1'b0;
                        end else begin
                            i_rdata <= m_rdata;
                            i_err   <= 1'b0;
                        end
                        state <= S_RESP;
                    end else if (timeout_hit) begin
                        if (owner == OWN_D) d_err <= 1'b1;
                        else                i_err <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // m_req is decoded from the state register, so an asynchronous reset drops
    // it at once. The m_* fields come only from the latched copy.
    assign m_req   = (state == S_ISSUE);
    assign m_we    = lat_we;
    assign m_addr  = lat_addr;
    assign m_wdata = lat_wdata;
    assign m_width = lat_width;

    assign i_ready = (state == S_RESP) && (owner == OWN_I);
    assign d_ready = (state == S_RESP) && (owner == OWN_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4). A table of single
// transactions carries hand-computed expectations. Hand-written sequences
// cover reset, contention, a stray ack and async reset mid-transaction.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [1:0]  d_width;
    logic        i_ready, i_err, d_ready, d_err;
    logic [31:0] i_rdata, d_rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_width;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_width(d_width),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_width(m_width),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        int          ack_k;     // ack in k-th ISSUE cycle, 0 = never
        logic [31:0] mrdata;
        logic        drop;      // release req as soon as m_req is seen
        logic        exp_we;
        logic [1:0]  exp_width;
        logic [31:0] exp_wdata;
        int          exp_cyc;   // cycles m_req stays high
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts at a negedge with the arbiter in IDLE and ends at a negedge back in IDLE.
    task automatic run_txn(input vec_t v);
        int waitc;
        int cyc;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_width = v.width;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        waitc = 0;
        do begin tick(); waitc++; end while (!m_req && waitc < 8);
        chk("grant_latency", waitc, 1);
        chk("m_addr", m_addr, v.addr);
        chk("m_we", m_we, v.exp_we);
        chk("m_width", m_width, v.exp_width);
        chk("m_wdata", m_wdata, v.exp_wdata);
        if (v.drop) begin i_req = 1'b0; d_req = 1'b0; end
        cyc = 0;
        while (m_req && cyc < 20) begin
            cyc++;
            chk("m_stable", {m_we, m_width, m_addr, m_wdata},
                {v.exp_we, v.exp_width, v.addr, v.exp_wdata});
            chk("no_ready_in_issue", {i_ready, d_ready}, 2'b00);
            // The requester moving its address must not disturb the memory side.
            if (v.is_d) d_addr = ~v.addr; else i_addr = ~v.addr;
            if (cyc == v.ack_k) begin m_ack = 1'b1; m_rdata = v.mrdata; end
            tick();
            m_ack = 1'b0;
        end
        chk("issue_cycles", cyc, v.exp_cyc);
        chk("ready_pulse", {i_ready, d_ready}, v.is_d ? 2'b01 : 2'b10);
        chk("rdata", v.is_d ? d_rdata : i_rdata, v.exp_rdata);
        chk("err", v.is_d ? d_err : i_err, v.exp_err);
        i_req = 1'b0; d_req = 1'b0;
        tick();
        chk("ready_end", {i_ready, d_ready, m_req}, 3'b000);
    endtask

    initial begin
        int waitc;
        vec_t fresh;
        //            is_d we addr          wdata         wd     k  mrdata        drop exp_we exp_wd exp_wdata   cyc err exp_rdata
        vecs[0] = '{1'b0, 1'b0, 32'h00400004, 32'h0,        2'b00, 1, 32'h00A00093, 1'b0, 1'b0, 2'b10, 32'h0,        1, 1'b0, 32'h00A00093};
        vecs[1] = '{1'b1, 1'b1, 32'h10010008, 32'hDEADBEEF, 2'b10, 4, 32'h12345678, 1'b0, 1'b1, 2'b10, 32'hDEADBEEF, 4, 1'b0, 32'h12345678};
        vecs[2] = '{1'b1, 1'b0, 32'h10010010, 32'h11111111, 2'b01, 2, 32'h0000BEEF, 1'b0, 1'b0, 2'b01, 32'h11111111, 2, 1'b0, 32'h0000BEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h10010020, 32'h0,        2'b10, 0, 32'hBAD0BAD0, 1'b0, 1'b0, 2'b10, 32'h0,        4, 1'b1, 32'h0000BEEF};
        vecs[4] = '{1'b1, 1'b0, 32'h10010024, 32'h0,        2'b00, 1, 32'h00000055, 1'b0, 1'b0, 2'b00, 32'h0,        1, 1'b0, 32'h00000055};
        vecs[5] = '{1'b0, 1'b0, 32'h00400008, 32'h0,        2'b00, 3, 32'h00000013, 1'b1, 1'b0, 2'b10, 32'h0,        3, 1'b0, 32'h00000013};
        vecs[6] = '{1'b0, 1'b0, 32'h0040000C, 32'h0,        2'b00, 0, 32'hBAD0BAD0, 1'b0, 1'b0, 2'b10, 32'h0,        4, 1'b1, 32'h00000013};
        vecs[7] = '{1'b0, 1'b0, 32'h00400010, 32'h0,        2'b00, 4, 32'hABCD0001, 1'b0, 1'b0, 2'b10, 32'h0,        4, 1'b0, 32'hABCD0001};

        // Reset with both requesters active: every output must read zero.
        rst_n = 1'b0; m_ack = 1'b0; m_rdata = '0;
        i_req = 1'b1; i_addr = 32'h00000100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00000200; d_wdata = 32'h0; d_width = 2'b01;
        tick(); tick();
        chk("reset_ctrl", {m_req, m_we, i_ready, d_ready, i_err, d_err}, 6'b0);
        chk("reset_m", {m_addr, m_wdata, m_width}, 66'h0);
        chk("reset_rdata", {i_rdata, d_rdata}, 64'h0);
        rst_n = 1'b1;

        // Contention: D first, then strict alternation; each ready one cycle wide.
        for (int n = 0; n < 6; n++) begin
            waitc = 0;
            do begin tick(); waitc++; end while (!m_req && waitc < 8);
            chk("cont_latency", waitc, 1);
            chk("cont_grant", m_addr, (n % 2 == 0) ? 32'h200 : 32'h100);
            m_ack = 1'b1; m_rdata = 32'hC0000000 + 32'(n);
            tick();
            m_ack = 1'b0;
            chk("cont_ready", {i_ready, d_ready}, (n % 2 == 0) ? 2'b01 : 2'b10);
            chk("cont_rdata", (n % 2 == 0) ? d_rdata : i_rdata, 32'hC0000000 + 32'(n));
            if (n == 5) begin i_req = 1'b0; d_req = 1'b0; end
            tick();
            chk("cont_gap", {i_ready, d_ready, m_req}, 3'b000);
        end

        // A stray ack in IDLE is ignored.
        m_ack = 1'b1; m_rdata = 32'hFFFFFFFF;
        tick();
        m_ack = 1'b0;
        chk("stray_ack", {i_ready, d_ready, m_req}, 3'b000);
        chk("stray_rdata", {i_rdata, d_rdata}, {32'hC0000005, 32'hC0000004});

        foreach (vecs[k]) run_txn(vecs[k]);

        // Async reset between edges while in ISSUE.
        i_req = 1'b1; i_addr = 32'h00400020;
        waitc = 0;
        do begin tick(); waitc++; end while (!m_req && waitc < 8);
        chk("ar_issue", m_req, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("ar_mreq_drop", {m_req, i_ready, d_ready}, 3'b000);
        chk("ar_rdata_clr", i_rdata, 32'h0);
        i_req = 1'b0;
        tick();
        chk("ar_no_ready", {i_ready, d_ready, m_req}, 3'b000);
        rst_n = 1'b1;
        tick();
        chk("ar_idle", {i_ready, d_ready, m_req}, 3'b000);
        fresh = '{1'b0, 1'b0, 32'h00400024, 32'h0, 2'b00, 1, 32'h00000297, 1'b0,
                  1'b0, 2'b10, 32'h0, 1, 1'b0, 32'h00000297};
        run_txn(fresh);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one backing memory port between the instruction-fetch requester and the data load/store requester.
- Uses round-robin arbitration and a latched request.
- Waits for a variable-latency acknowledge, guarded by a timeout.
- Sits between the fetch/LSU stages and the unified memory model. It sequences single-beat transactions and returns read data with a one-cycle ready pulse.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT, 255, max cycles waiting for m_ack before abort; 0 disables timeout

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  instruction fetch request, level, held until i_ready
i_addr  in  ADDR_W  fetch byte address
i_ready  out  1  one-cycle pulse: fetch complete, i_rdata/i_err valid
i_rdata  out  DATA_W  fetched word
i_err  out  1  timeout on this fetch, valid with i_ready
d_req  in  1  data request, level, held until d_ready
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  store data
d_width  in  2  access width code, passed through unchanged
d_ready  out  1  one-cycle pulse: data access complete
d_rdata  out  DATA_W  load data (undefined-but-stable for stores: holds m_rdata captured)
d_err  out  1  timeout on this access, valid with d_ready
m_req  out  1  memory request, held until m_ack or timeout
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_width  out  2  memory width code (2'b10 forced for fetches)
m_ack  in  1  memory completion, one cycle; m_rdata valid same cycle
m_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (async assert, sync-release use): state=IDLE; all outputs 0; last_grant=I; timeout counter=0.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - no req -> stay.
  - Only i_req -> grant I. Only d_req -> grant D.
  - Both -> grant the side not in last_grant (reset value makes D win the first tie).
  - On grant, latch owner, addr, we, wdata, width into registers; update last_grant; counter=0; go ISSUE.
  - Fetch latches we=0, width=2'b10, wdata=0.
- ISSUE:
  - m_req=1; m_* driven from latched registers only, stable for the whole state.
  - m_ack=1 -> capture m_rdata into owner's rdata register, err=0, go RESP.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1 -> err=1, rdata unchanged, go RESP; otherwise counter++.
  - m_ack in the same cycle as timeout expiry counts as success.
- RESP:
  - m_req=0; owner's ready=1 for exactly this cycle; other ready=0; go IDLE.
  - rdata/err registers hold until the next completion for that side.
- Latency: req seen in IDLE at cycle N; m_req high at N+1; m_ack at N+1 earliest; ready at N+2. Minimum 3 cycles per transaction; back-to-back grants re-arbitrate in IDLE.
- m_ack outside ISSUE is ignored.
- Requester drops req mid-transaction: transaction still completes and ready still pulses. Requests never abort.
- Requester changes addr while waiting: no effect (latched).
- A new req arriving during ISSUE/RESP waits for IDLE.
- Fairness: with both reqs continuously high, grants strictly alternate I, D, I, D after the first D.
- rst_n asserted mid-ISSUE: m_req drops asynchronously, no ready pulse, state IDLE; the pending transaction is lost.

Test Plan:
- Reset: rst_n=0 with i_req=d_req=1 -> all outputs 0. Release -> first grant D: m_addr=d_addr at cycle+1.
- Single fetch: i_addr=0x00400004, memory acks 1 cycle after m_req with 0x00A00093 -> m_we=0, m_width=2'b10, i_ready pulse 1 cycle with i_rdata=0x00A00093, i_err=0. Total 3 cycles.
- Store: d_we=1, d_addr=0x10010008, d_wdata=0xDEADBEEF, d_width=2'b10, ack after 4 cycles -> m_* stable for 4 cycles, d_ready single pulse, d_err=0, i_ready stays 0.
- Contention: i_req and d_req held high for 6 transactions, ack immediate -> grant order D,I,D,I,D,I; each ready one cycle wide.
- Timeout: TIMEOUT=4, m_ack never asserted on a load -> m_req high exactly 4 cycles, then d_ready=1 with d_err=1, d_rdata unchanged. The next request proceeds normally.
- Async reset mid-ISSUE: assert rst_n=0 between clock edges during ISSUE -> m_req=0 immediately, no ready pulse. After release, a fresh i_req completes normally.
